// File: rtl/slink_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : slink_frame_sched
// Purpose  : Shares one two-wire serial link (scl/sda) between NREQ
//            requesters. Arbitrates in IDLE, then sends the winner's 4-bit
//            code as one frame: start, 4 data bits MSB first, stop, gap.
//            The frame is 22 link phases of DIV clocks each.
// Ports    : clk     - system clock, rising edge
//            rst_n   - synchronous active-low reset
//            req     - level request per requester, held until granted
//            code    - 4-bit code per requester, code[4*i+3:4*i]
//            gnt     - one-hot, one-cycle grant pulse (combinational in IDLE)
//            cur_id  - index of requester owning the current/last frame
//            busy    - high from the cycle after grant through done
//            done    - one-cycle pulse on the last clock of the frame
//            scl/sda - link clock/data, both idle high
// Options  : SLINK_FIXED_PRIO_EN - fixed priority (lowest index wins),
//            round-robin pointer removed. Frame timing is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module slink_frame_sched #(
    parameter int NREQ = 4,
    parameter int DIV  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] code,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        cur_id,
    output logic              busy,
    output logic              done,
    output logic              scl,
    output logic              sda
);

    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_START   = 3'd1;
    localparam logic [2:0]  ST_BIT     = 3'd2;
    localparam logic [2:0]  ST_STOP    = 3'd3;
    localparam logic [2:0]  ST_GAP     = 3'd4;
    localparam logic [15:0] C_DIV_LAST = 16'(DIV - 1);

    logic [2:0]  state_q,   state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [1:0]  ph_q,      ph_d;       // phase index within the current state
    logic [1:0]  bit_q,     bit_d;      // data bit being sent, 3 down to 0
    logic [3:0]  code_q,    code_d;
    logic [2:0]  cur_id_q,  cur_id_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        scl_q,     scl_d;
    logic        sda_q,     sda_d;
`ifndef SLINK_FIXED_PRIO_EN
    logic [2:0]  ptr_q,     ptr_d;      // last winner; search starts after it
`endif

    logic [2:0]  w_win;
    logic [3:0]  w_code_sel;
    logic        w_take;
    logic        w_phase_end;

    // Link levels {scl, sda} for a given position in the frame.
    function automatic logic [1:0] link_levels(input logic [2:0] st,
                                               input logic [1:0] ph,
                                               input logic [1:0] b,
                                               input logic [3:0] c);
        logic [1:0] lv;
        case (st)
            ST_START: lv = (ph == 2'd0) ? 2'b10 : 2'b00;
            ST_BIT:   lv = {(ph == 2'd1) || (ph == 2'd2), c[b]};
            ST_STOP:  lv = (ph == 2'd0) ? 2'b00 : ((ph == 2'd1) ? 2'b10 : 2'b11);
            default:  lv = 2'b11;
        endcase
        return lv;
    endfunction

    // Arbiter: picks the winner among the set req bits.
    always_comb begin
        w_win = 3'd0;
`ifdef SLINK_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = 3'(i);
        end
`else
        begin : blk_rr
            logic found;
            found = 1'b0;
            for (int off = 1; off <= NREQ; off++) begin
                if (!found && req[(int'(ptr_q) + off) % NREQ]) begin
                    found = 1'b1;
                    w_win = 3'((int'(ptr_q) + off) % NREQ);
                end
            end
        end
`endif
    end

    // Reset gates the grant so no pulse escapes while rst_n is low.
    assign w_take      = (state_q == ST_IDLE) && (|req) && rst_n;
    assign w_phase_end = (div_cnt_q == C_DIV_LAST);

    always_comb begin
        w_code_sel = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = w_take && (w_win == 3'(i));
            if (w_win == 3'(i)) w_code_sel = code[4*i +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        code_d    = code_q;
        cur_id_d  = cur_id_q;
`ifndef SLINK_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        if (state_q == ST_IDLE) begin
            if (w_take) begin
                state_d   = ST_START;
                div_cnt_d = 16'd0;
                ph_d      = 2'd0;
                bit_d     = 2'd3;
                code_d    = w_code_sel;
                cur_id_d  = w_win;
`ifndef SLINK_FIXED_PRIO_EN
                ptr_d     = w_win;
`endif
            end
        end else if (w_phase_end) begin
            div_cnt_d = 16'd0;
            ph_d      = ph_q + 2'd1;      // wraps 3->0 between data bits
            case (state_q)
                ST_START: if (ph_q == 2'd1) begin
                    state_d = ST_BIT;
                    ph_d    = 2'd0;
                end
                ST_BIT: if (ph_q == 2'd3) begin
                    if (bit_q == 2'd0) state_d = ST_STOP;
                    else               bit_d   = bit_q - 2'd1;
                end
                ST_STOP: if (ph_q == 2'd2) begin
                    state_d = ST_GAP;
                    ph_d    = 2'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    ph_d    = 2'd0;
                end
            endcase
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end

        // Outputs are registered from the next state so they change on the
        // first clock of each phase.
        {scl_d, sda_d} = link_levels(state_d, ph_d, bit_d, code_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GAP) && (div_cnt_d == C_DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= 16'd0;
            ph_q      <= 2'd0;
            bit_q     <= 2'd0;
            code_q    <= 4'd0;
            cur_id_q  <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
`ifndef SLINK_FIXED_PRIO_EN
            ptr_q     <= 3'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            code_q    <= code_d;
            cur_id_q  <= cur_id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
`ifndef SLINK_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // cur_id shows the winner already in the grant cycle.
    assign cur_id = w_take ? w_win : cur_id_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign scl    = scl_q;
    assign sda    = sda_q;

endmodule
`default_nettype wire

// File: tb/tb_slink_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_slink_frame_sched
// Purpose  : Self-checking bench for slink_frame_sched (NREQ=4, DIV=2).
//            A frame-level model predicts every output on every cycle;
//            a link decoder recovers the sent codes for literal checks.
// Options  : SLINK_FIXED_PRIO_EN switches model and literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slink_frame_sched;

    localparam int NREQ  = 4;
    localparam int DIV   = 2;
    localparam int FRAME = 22 * DIV;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] code;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        cur_id;
    logic              busy, done, scl, sda;

    slink_frame_sched #(.NREQ(NREQ), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .code(code), .gnt(gnt),
        .cur_id(cur_id), .busy(busy), .done(done), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- frame-level model ----------------
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
`ifdef SLINK_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int off = 1; off <= NREQ; off++)
            if (r[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
`endif
        return -1;
    endfunction

    // {scl, sda} for phase p (0..21) of a frame carrying code c.
    function automatic logic [1:0] frame_out(input int p, input logic [3:0] c);
        int q;
        if (p == 0) return 2'b10;
        if (p == 1) return 2'b00;
        if (p < 18) begin
            q = (p - 2) % 4;
            return {(q == 1) || (q == 2), c[3 - (p - 2) / 4]};
        end
        if (p == 18) return 2'b00;
        if (p == 19) return 2'b10;
        return 2'b11;
    endfunction

    logic       m_active = 1'b0;
    int         m_k = 0;
    logic [3:0] m_code = 4'd0;
    int         m_cur = 0;
    int         m_ptr = NREQ - 1;
    logic       cmp_en = 1'b0;

    always @(posedge clk) begin
        cmp_en <= 1'b1;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_cur    <= 0;
            m_ptr    <= NREQ - 1;
        end else if (!m_active) begin
            if (pick(req, m_ptr) >= 0) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_code   <= code[4*pick(req, m_ptr) +: 4];
                m_cur    <= pick(req, m_ptr);
                m_ptr    <= pick(req, m_ptr);
            end
        end else begin
            if (m_k == FRAME - 1) m_active <= 1'b0;
            m_k <= m_k + 1;
        end
    end

    logic [NREQ-1:0] e_gnt;
    logic [2:0]      e_cur;
    logic            e_busy, e_done, e_scl, e_sda;
    int              e_w;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!m_active) begin
                e_scl  = 1'b1;
                e_sda  = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b0;
                e_w    = rst_n ? pick(req, m_ptr) : -1;
                e_gnt  = '0;
                if (e_w >= 0) e_gnt[e_w] = 1'b1;
                e_cur  = (e_w >= 0) ? 3'(e_w) : 3'(m_cur);
            end else begin
                {e_scl, e_sda} = frame_out(m_k / DIV, m_code);
                e_busy = 1'b1;
                e_done = (m_k == FRAME - 1);
                e_gnt  = '0;
                e_cur  = 3'(m_cur);
            end
            check("outputs{gnt,cur_id,busy,done,scl,sda}",
                  {gnt, cur_id, busy, done, scl, sda},
                  {e_gnt, e_cur, e_busy, e_done, e_scl, e_sda});
        end
    end

    // ---------------- link decoder ----------------
    logic       prev_scl = 1'b1, prev_sda = 1'b1, rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [3:0] rx_sh = 4'd0;
    logic [3:0] rxq[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            if (prev_scl && scl && prev_sda && !sda) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end else if (rx_on && !prev_scl && scl) begin
                rx_sh = {rx_sh[2:0], sda};
                rx_cnt++;
                if (rx_cnt == 4) begin
                    rxq.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int t, output logic [NREQ-1:0] g,
                              output logic [2:0] id, input int budget);
        t = -1; g = '0; id = 3'd0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                t = cyc; g = gnt; id = cur_id;
                break;
            end
        end
        check("grant_seen", (t >= 0), 1'b1);
    endtask

    task automatic wait_done(output int t, input int budget);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("done_seen", (t >= 0), 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200us");
        $fatal(1, "timeout");
    end

    int              t0, t1, td;
    logic [NREQ-1:0] g;
    logic [2:0]      id;
    int              exp_rr[5];
    int              exp_alt[3];
    logic [3:0]      got_code;

    initial begin
`ifdef SLINK_FIXED_PRIO_EN
        exp_rr  = '{0, 0, 0, 0, 0};
        exp_alt = '{0, 0, 0};
`else
        exp_rr  = '{0, 1, 2, 3, 0};
        exp_alt = '{0, 3, 0};
`endif
        rst_n = 1'b0;
        req   = '0;
        code  = '0;

        // Reset state, then idle with no requests.
        step(3);
        @(negedge clk);
        check("reset_state", {gnt, cur_id, busy, done, scl, sda}, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(5);
        @(negedge clk);
        check("idle_no_req", {gnt, cur_id, busy, done, scl, sda}, {4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});

        // Single frame from requester 2 with code 1010.
        @(posedge clk); #1;
        rxq.delete();
        code = 16'h0A00;
        req  = 4'b0100;
        wait_grant(t0, g, id, 20);
        check("single_gnt", g, 4'b0100);
        check("single_cur_id", id, 3'd2);
        @(posedge clk); #1;
        req = '0;
        wait_done(td, 100);
        check("single_done_offset", td - t0, 44);
        step(3);
        check("single_rx_count", rxq.size(), 1);
        got_code = (rxq.size() > 0) ? rxq.pop_front() : 4'hX;
        check("single_rx_code", got_code, 4'b1010);

        // Round-robin with all four requesting, after a fresh reset.
        do_reset(2);
        rxq.delete();
        code = 16'h4321;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(t1, g, id, 60);
            if (i == 0) t0 = t1;
            check("rr_grant_id", id, 3'(exp_rr[i]));
            check("rr_grant_time", t1 - t0, 45 * i);
        end
        @(posedge clk); #1;
        req = '0;
        wait_done(td, 100);
        step(3);
        check("rr_rx_count", rxq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got_code = (rxq.size() > 0) ? rxq.pop_front() : 4'hX;
            check("rr_rx_code", got_code, 4'(exp_rr[i] + 1));
        end

        // Request rising during a frame waits for IDLE.
        req = 4'b0001;
        wait_grant(t0, g, id, 20);
        @(posedge clk); #1;
        req = '0;
        step(9);
        req = 4'b0010;
        wait_grant(t1, g, id, 80);
        check("mask_gnt", g, 4'b0010);
        check("mask_grant_offset", t1 - t0, 45);
        @(posedge clk); #1;
        req = '0;
        wait_done(td, 100);
        step(2);

        // Reset during the first bit's scl-high phase.
        rxq.delete();
        req = 4'b0001;
        wait_grant(t0, g, id, 20);
        @(posedge clk); #1;
        req = '0;
        step(6);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_in_b1_scl", scl, 1'b1);
        @(posedge clk); #1;
        req = 4'b1000;
        @(negedge clk);
        check("midreset_after", {gnt, busy, done, scl, sda}, {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_grant(t0, g, id, 20);
        check("midreset_regrant", g, 4'b1000);
        check("midreset_cur_id", id, 3'd3);
        @(posedge clk); #1;
        req = '0;
        wait_done(td, 100);
        step(3);
        check("midreset_rx_count", rxq.size(), 1);
        got_code = (rxq.size() > 0) ? rxq.pop_front() : 4'hX;
        check("midreset_rx_code", got_code, 4'b0100);

        // Requesters 0 and 3 held: alternate under round-robin,
        // requester 0 only under fixed priority.
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            wait_grant(t1, g, id, 60);
            if (i == 0) t0 = t1;
            check("pair_grant_id", id, 3'(exp_alt[i]));
            check("pair_grant_time", t1 - t0, 45 * i);
        end
        @(posedge clk); #1;
        req = '0;
        wait_done(td, 100);
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
